// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - runtime-programmable Moore serial pattern detector
// KMP next-state logic is computed from Pattern every cycle, so no table needs loading.
module seq_detector_param #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8,
  parameter int ST_W  = $clog2(PAT_W + 1)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Clr,
  input  logic             En,
  input  logic             In,
  input  logic [PAT_W-1:0] Pattern,
  input  logic             Overlap,
  output logic             OP,
  output logic [CNT_W-1:0] Match_Count,
  output logic [ST_W-1:0]  CS,
  output logic [ST_W-1:0]  NS
);

  localparam logic [ST_W-1:0] MATCH_ST = ST_W'(PAT_W);

  logic [ST_W-1:0] nxt;
  logic            hit;

  // Longest prefix of pat that is a suffix of (first k pattern bits, then b).
  // Bit strings are held MSB-first, so a prefix of length j is pat >> (PAT_W-j).
  function automatic logic [ST_W-1:0] kmp_next(input logic [ST_W-1:0] k,
                                               input logic            b,
                                               input logic [PAT_W-1:0] pat);
    logic [PAT_W:0]  hist;
    logic [PAT_W:0]  mask;
    logic [PAT_W:0]  pre;
    logic [ST_W-1:0] res;
    hist = {1'b0, pat} >> (PAT_W - int'(k));
    hist = {hist[PAT_W-1:0], b};
    res  = '0;
    for (int j = 1; j <= PAT_W; j++) begin
      mask = {(PAT_W + 1){1'b1}} >> (PAT_W + 1 - j);
      pre  = {1'b0, pat} >> (PAT_W - j);
      if ((j <= int'(k) + 1) && ((hist & mask) == pre))
        res = ST_W'(j);
    end
    return res;
  endfunction

  always_comb begin
    nxt = CS;
    if (Clr) begin
      nxt = '0;
    end else if (CS > MATCH_ST) begin
      nxt = '0;
    end else if (En) begin
      if ((CS == MATCH_ST) && !Overlap)
        nxt = (In == Pattern[PAT_W-1]) ? ST_W'(1) : '0;
      else
        nxt = kmp_next(CS, In, Pattern);
    end
  end

  assign NS  = nxt;
  assign hit = En && !Clr && (nxt == MATCH_ST);
  assign OP  = (CS == MATCH_ST);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      CS          <= '0;
      Match_Count <= '0;
    end else begin
      CS <= NS;
      if (Clr)
        Match_Count <= '0;
      else if (hit && (Match_Count != {CNT_W{1'b1}}))
        Match_Count <= Match_Count + 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - directed bench for seq_detector_param
// A second instance with a 2-bit counter covers saturation.
module tb_seq_detector_param;

  logic       Clk = 1'b0;
  logic       Rst, Clr, En, In, Overlap;
  logic [3:0] Pattern;
  logic       OP;
  logic [7:0] Match_Count;
  logic [2:0] CS, NS;
  logic       s_op;
  logic [1:0] s_count;
  logic [2:0] s_cs, s_ns;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  seq_detector_param #(.PAT_W(4), .CNT_W(8)) dut (
    .Clk(Clk), .Rst(Rst), .Clr(Clr), .En(En), .In(In), .Pattern(Pattern),
    .Overlap(Overlap), .OP(OP), .Match_Count(Match_Count), .CS(CS), .NS(NS)
  );

  seq_detector_param #(.PAT_W(4), .CNT_W(2)) dut_s (
    .Clk(Clk), .Rst(Rst), .Clr(Clr), .En(En), .In(In), .Pattern(Pattern),
    .Overlap(Overlap), .OP(s_op), .Match_Count(s_count), .CS(s_cs), .NS(s_ns)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge Clk);
    Clr = 1'b0;
    En  = 1'b1;
    In  = b;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      Clr = 1'b0;
      En  = 1'b0;
      @(posedge Clk);
      #1;
    end
  endtask

  // Clr asserted together with an accepted bit: the bit must be discarded.
  task automatic pulse_clr();
    @(negedge Clk);
    Clr = 1'b1;
    En  = 1'b1;
    In  = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  logic       bits1 [8]  = '{1, 0, 1, 0, 1, 0, 1, 0};
  logic [2:0] cs1   [8]  = '{1, 2, 3, 4, 1, 2, 3, 4};
  logic       bits2 [6]  = '{1, 0, 1, 0, 1, 0};
  logic [2:0] cs2o  [6]  = '{1, 2, 3, 4, 3, 4};
  logic [2:0] cs2n  [6]  = '{1, 2, 3, 4, 1, 2};
  logic [1:0] sat   [8]  = '{0, 0, 0, 1, 2, 3, 3, 3};

  initial begin
    Rst = 1'b0; Clr = 1'b0; En = 1'b0; In = 1'b0;
    Pattern = 4'b1010; Overlap = 1'b0;
    #12;
    check("reset_cs", CS, 0);
    check("reset_op", OP, 0);
    check("reset_count", Match_Count, 0);
    @(negedge Clk);
    Rst = 1'b1;

    // 1010 non-overlapping, two back-to-back matches
    pulse_clr();
    for (int i = 0; i < 8; i++) begin
      send_bit(bits1[i]);
      check($sformatf("t1_cs%0d", i), CS, cs1[i]);
      check($sformatf("t1_op%0d", i), OP, (cs1[i] == 3'd4));
    end
    check("t1_count", Match_Count, 2);

    // 1010 overlapping vs non-overlapping on 101010
    Overlap = 1'b1;
    pulse_clr();
    for (int i = 0; i < 6; i++) begin
      send_bit(bits2[i]);
      check($sformatf("t2o_cs%0d", i), CS, cs2o[i]);
    end
    check("t2o_count", Match_Count, 2);
    Overlap = 1'b0;
    pulse_clr();
    for (int i = 0; i < 6; i++) begin
      send_bit(bits2[i]);
      check($sformatf("t2n_cs%0d", i), CS, cs2n[i]);
    end
    check("t2n_count", Match_Count, 1);

    // 1111 with five ones
    Pattern = 4'b1111;
    Overlap = 1'b1;
    pulse_clr();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    check("t3o_cs", CS, 4);
    check("t3o_count", Match_Count, 2);
    Overlap = 1'b0;
    pulse_clr();
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    check("t3n_cs", CS, 1);
    check("t3n_count", Match_Count, 1);

    // En gaps between bits; match state held without re-counting
    Pattern = 4'b1010;
    pulse_clr();
    for (int i = 0; i < 4; i++) begin
      send_bit(bits1[i]);
      idle(3);
      check($sformatf("t4_hold_cs%0d", i), CS, cs1[i]);
      check($sformatf("t4_ns%0d", i), NS, cs1[i]);
    end
    check("t4_op_held", OP, 1);
    check("t4_count", Match_Count, 1);

    // saturation on the 2-bit counter, then clear
    Pattern = 4'b1111;
    Overlap = 1'b1;
    pulse_clr();
    check("t5_clr_prio_cs", s_cs, 0);
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1);
      check($sformatf("t5_sat%0d", i), s_count, sat[i]);
    end
    check("t5_cs", s_cs, 4);
    pulse_clr();
    check("t5_clr_count", s_count, 0);
    check("t5_clr_cs", s_cs, 0);
    check("t5_clr_op", s_op, 0);

    // asynchronous reset mid-cycle
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    check("t6_pre_cs", CS, 1);
    #2;
    Rst = 1'b0;
    #1;
    check("t6_rst_cs", CS, 0);
    check("t6_rst_op", OP, 0);
    check("t6_rst_count", Match_Count, 0);
    @(negedge Clk);
    Rst = 1'b1;
    En  = 1'b0;
    send_bit(1'b0);
    send_bit(1'b1);
    check("t6_mid_cs", CS, 1);
    send_bit(1'b0);
    check("t6_end_cs", CS, 0);
    check("t6_end_op", OP, 0);
    check("t6_end_count", Match_Count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
